// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle
// on operand magnitudes, followed by a single sign-correction/commit cycle.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t state;
    state_t next_state;

    // Latched operation context; operand holds the multiplicand or the divisor.
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             zero_div;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] operand;
    logic [2*WIDTH-1:0] acc;

    // Request decode and per-step datapath values.
    logic               req_div;
    logic               req_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Decode the incoming request into magnitudes and sign flags.
    always_comb begin
        req_div    = op[1];
        req_signed = ~op[0];
        a_neg      = req_signed & in_a[WIDTH-1];
        b_neg      = req_signed & in_b[WIDTH-1];
        mag_a      = a_neg ? -in_a : in_a;
        mag_b      = b_neg ? -in_b : in_b;
    end

    // One iteration: multiply adds into the upper half and shifts right,
    // divide shifts left and keeps the trial subtraction when it does not borrow.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + {1'b0, (acc[0] ? operand : {WIDTH{1'b0}})};
        rem_shift = acc[2*WIDTH-1:WIDTH-1];
        diff      = rem_shift - {1'b0, operand};
        if (is_div) begin
            if (diff[WIDTH]) begin
                step_acc = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                step_acc = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            step_acc = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Sign correction of the finished magnitude result; a zero divisor
    // forces an all-ones quotient while the remainder becomes the dividend.
    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (zero_div) begin
            quot_fix = {WIDTH{1'b1}};
        end else begin
            quot_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and busy flag.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (count == LAST) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: latch on start, iterate in RUN, commit in FIX, direct
    // HI/LO writes only while idle and not starting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero_div    <= 1'b0;
            count       <= '0;
            operand     <= '0;
            acc         <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        is_div   <= req_div;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        zero_div <= req_div & (in_b == '0);
                        operand  <= req_div ? mag_b : mag_a;
                        acc      <= {{WIDTH{1'b0}}, (req_div ? mag_a : mag_b)};
                        count    <= '0;
                    end else begin
                        if (hi_we) begin
                            hi <= wdata;
                        end
                        if (lo_we) begin
                            lo <= wdata;
                        end
                    end
                end
                RUN: begin
                    acc   <= step_acc;
                    count <= count + CW'(1);
                end
                FIX: begin
                    if (is_div) begin
                        lo          <= quot_fix;
                        hi          <= rem_fix;
                        div_by_zero <= zero_div;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_mul_div_unit;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic        start   = 1'b0;
    logic [1:0]  op      = 2'b00;
    logic [31:0] in_a    = '0;
    logic [31:0] in_b    = '0;
    logic        hi_we   = 1'b0;
    logic        lo_we   = 1'b0;
    logic [31:0] wdata   = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    int          first_done;
    int          done_cnt;
    int          busy_cnt;
    int          dbz_cnt;
    logic [31:0] got_hi;
    logic [31:0] got_lo;
    logic        got_dbz;
    logic        held_ok;

    mul_div_unit #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .op         (op),
        .in_a       (in_a),
        .in_b       (in_b),
        .hi_we      (hi_we),
        .lo_we      (lo_we),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .hi         (hi),
        .lo         (lo)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference result: {div_by_zero, hi, lo}.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        int          q;
        int          r;
        sa = int'(a);
        sb = int'(b);
        case (o)
            2'b00: begin
                sp = longint'(sa) * longint'(sb);
                return {1'b0, 64'(sp)};
            end
            2'b01: begin
                up = {32'h0, a} * {32'h0, b};
                return {1'b0, up};
            end
            2'b10: begin
                if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return {1'b0, 32'h0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, 32'(r), 32'(q)};
            end
            default: begin
                if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    // Issue one operation and observe 40 cycles after the accepting edge.
    task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] a,
                                  input logic [31:0] b, input bit with_we,
                                  input int restart_at);
        logic [31:0] hi0;
        logic [31:0] lo0;
        @(negedge clk);
        hi0   = hi;
        lo0   = lo;
        start = 1'b1;
        op    = o;
        in_a  = a;
        in_b  = b;
        hi_we = with_we;
        lo_we = with_we;
        wdata = $urandom;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom);
        in_a  = $urandom;
        in_b  = $urandom;
        hi_we = 1'b0;
        lo_we = 1'b0;
        first_done = 0;
        done_cnt   = 0;
        dbz_cnt    = 0;
        busy_cnt   = busy ? 1 : 0;
        held_ok    = 1'b1;
        got_hi     = '0;
        got_lo     = '0;
        got_dbz    = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                done_cnt++;
                if (first_done == 0) begin
                    first_done = c;
                    got_hi     = hi;
                    got_lo     = lo;
                    got_dbz    = div_by_zero;
                end
            end else if (first_done == 0 && (hi !== hi0 || lo !== lo0)) begin
                held_ok = 1'b0;
            end
            if (div_by_zero) dbz_cnt++;
            if (busy) busy_cnt++;
            if (c < 20) begin
                hi_we = 1'($urandom_range(0, 1));
                lo_we = 1'($urandom_range(0, 1));
                wdata = $urandom;
            end else begin
                hi_we = 1'b0;
                lo_we = 1'b0;
            end
            if (c == restart_at - 1) begin
                start = 1'b1;
                op    = 2'($urandom);
                in_a  = $urandom;
                in_b  = $urandom;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic run_and_check(input string tag, input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input bit with_we, input int restart_at);
        logic [64:0] exp;
        exp = model(o, a, b);
        apply_stimulus(o, a, b, with_we, restart_at);
        check_output({tag, " latency"}, 64'(first_done), 64'(LAT));
        check_output({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
        check_output({tag, " busy_cycles"}, 64'(busy_cnt), 64'(LAT));
        check_output({tag, " hi"}, {32'h0, got_hi}, {32'h0, exp[63:32]});
        check_output({tag, " lo"}, {32'h0, got_lo}, {32'h0, exp[31:0]});
        check_output({tag, " dbz"}, {63'h0, got_dbz}, {63'h0, exp[64]});
        check_output({tag, " dbz_cycles"}, 64'(dbz_cnt), {63'h0, exp[64]});
        check_output({tag, " hold"}, {63'h0, held_ok}, 64'd1);
    endtask

    // Directed and random sequence.
    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          late_done;

        #3 reset_n = 1'b0;
        #1;
        check_output("reset busy", {63'h0, busy}, 64'd0);
        check_output("reset done", {63'h0, done}, 64'd0);
        check_output("reset dbz", {63'h0, div_by_zero}, 64'd0);
        check_output("reset hi", {32'h0, hi}, 64'd0);
        check_output("reset lo", {32'h0, lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_and_check("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 0);
        check_output("mult_neg const hi", {32'h0, got_hi}, 64'hFFFF_FFFF);
        check_output("mult_neg const lo", {32'h0, got_lo}, 64'hFFFF_FFEB);

        run_and_check("divu_100_7", 2'b11, 32'd100, 32'd7, 1'b0, 0);
        check_output("divu const lo", {32'h0, got_lo}, 64'd14);
        check_output("divu const hi", {32'h0, got_hi}, 64'd2);

        run_and_check("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        check_output("div_neg const lo", {32'h0, got_lo}, 64'hFFFF_FFFD);
        check_output("div_neg const hi", {32'h0, got_hi}, 64'hFFFF_FFFF);

        run_and_check("div_zero", 2'b10, 32'h1234_5678, 32'd0, 1'b0, 0);
        check_output("div_zero const hi", {32'h0, got_hi}, 64'h1234_5678);
        check_output("div_zero const dbz", {63'h0, got_dbz}, 64'd1);

        run_and_check("divu_zero", 2'b11, 32'hDEAD_BEEF, 32'd0, 1'b0, 0);
        run_and_check("div_neg_zero", 2'b10, 32'h8000_0001, 32'd0, 1'b0, 0);

        run_and_check("multu_max_restart", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 10);
        check_output("multu const hi", {32'h0, got_hi}, 64'hFFFF_FFFE);
        check_output("multu const lo", {32'h0, got_lo}, 64'h0000_0001);

        run_and_check("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        run_and_check("mult_min_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
        run_and_check("start_wins", 2'b01, 32'h0001_0003, 32'h0000_0005, 1'b1, 0);

        @(negedge clk);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check_output("mthi_mtlo hi", {32'h0, hi}, 64'hCAFE_F00D);
        check_output("mthi_mtlo lo", {32'h0, lo}, 64'hCAFE_F00D);
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'h1111_2222;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        check_output("mthi only hi", {32'h0, hi}, 64'h1111_2222);
        check_output("mthi only lo", {32'h0, lo}, 64'hCAFE_F00D);

        @(negedge clk);
        start = 1'b1;
        op    = 2'b11;
        in_a  = 32'd1000;
        in_b  = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_output("abort hi", {32'h0, hi}, 64'd0);
        check_output("abort lo", {32'h0, lo}, 64'd0);
        check_output("abort busy", {63'h0, busy}, 64'd0);
        check_output("abort done", {63'h0, done}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n   = 1'b1;
        late_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done) late_done++;
        end
        check_output("abort no_done", 64'(late_done), 64'd0);
        check_output("abort idle_busy", {63'h0, busy}, 64'd0);
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'd5;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        check_output("post_abort mthi", {32'h0, hi}, 64'd5);
        check_output("post_abort lo", {32'h0, lo}, 64'd0);

        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_and_check("first_cycle_start", 2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b0, 0);

        for (int n = 0; n < 30; n++) begin
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'($urandom_range(0, 200));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'h0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_and_check($sformatf("rand%0d", n), ro, ra, rb, 1'($urandom_range(0, 1)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width (even, >= 8).
REQ-002 SHALL have input clk, 1 bit, single clock; all state updates on its rising edge.
REQ-003 SHALL have input reset_n, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have input start, 1 bit, request to begin an operation.
REQ-005 SHALL have input op, 2 bits: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 SHALL have inputs in_a and in_b, WIDTH bits each: multiplicand/dividend and multiplier/divisor.
REQ-007 SHALL have inputs hi_we and lo_we, 1 bit each, plus input wdata, WIDTH bits, for direct HI/LO writes (MTHI/MTLO).
REQ-008 SHALL have output busy, 1 bit: operation in progress.
REQ-009 SHALL have output done, 1 bit: one-cycle pulse when a result is committed.
REQ-010 SHALL have output div_by_zero, 1 bit: valid with done; set only for DIV/DIVU with in_b == 0.
REQ-011 SHALL have outputs hi and lo, WIDTH bits each: registered HI and LO.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and FIX; the unit SHALL leave reset in IDLE.
REQ-013 In IDLE with start=1 at edge E0, SHALL latch op, operand magnitudes and result signs, clear the iteration counter, and enter RUN.
REQ-014 RUN SHALL perform exactly one iteration per cycle for WIDTH cycles (edges E1..E_WIDTH): shift-add for multiply, restoring shift-subtract for divide, then enter FIX.
REQ-015 FIX SHALL apply sign correction at edge E_WIDTH+1, write hi/lo, pulse done for exactly one cycle, and return to IDLE.
REQ-016 Fixed latency: done=1 and hi/lo valid in the cycle following edge E_WIDTH+1 (WIDTH+1 edges after start is sampled).
REQ-017 busy SHALL be 1 from after E0 through E_WIDTH+1 and 0 otherwise.
REQ-018 A start arriving while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-019 MULT/MULTU SHALL produce the full 2*WIDTH-bit product: {hi,lo} = in_a*in_b, two's complement for MULT.
REQ-020 DIV/DIVU SHALL write the quotient to lo and the remainder to hi.
REQ-021 Signed divide SHALL truncate the quotient toward zero; the remainder SHALL take the sign of the dividend.
REQ-022 Signed MIN/-1 SHALL yield lo=MIN, hi=0, with no flag.
REQ-023 Division by zero SHALL keep the same latency, yield lo=all ones and hi=in_a, and assert div_by_zero together with done.
REQ-024 In IDLE without start, hi_we SHALL load hi<=wdata and lo_we SHALL load lo<=wdata at the next edge; both may be asserted in the same cycle.
REQ-025 hi_we/lo_we SHALL be ignored while busy=1, and also when start=1 in the same cycle (start wins).
REQ-026 In-flight operands SHALL be latched copies; changes on in_a/in_b/op after E0 SHALL NOT affect the result.
REQ-027 hi/lo SHALL hold their value between commits; an operation in progress SHALL NOT alter them before FIX.

Reset
REQ-028 On reset_n=0, SHALL immediately and asynchronously force state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, and counter=0.
REQ-029 Reset asserted mid-operation SHALL abort the operation with no done pulse and no hi/lo update.
REQ-030 After reset_n deasserts, a start in the first clock cycle SHALL be accepted normally.

Verification
REQ-031 (WIDTH=32) MULT in_a=0xFFFFFFFD, in_b=7 -> done at edge 33 after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 33 cycles.
REQ-032 DIVU 100/7 -> lo=14, hi=2, div_by_zero=0.
REQ-033 DIV 0xFFFFFFF9 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 DIV in_a=0x12345678, in_b=0 -> lo=0xFFFFFFFF, hi=0x12345678, div_by_zero=1 for one cycle.
REQ-035 MULTU 0xFFFFFFFF*0xFFFFFFFF, second start at edge 10 with different operands -> result hi=0xFFFFFFFE, lo=0x00000001; only one done pulse.
REQ-036 MTHI/MTLO then DIVU started, reset_n pulsed low at edge 15 -> hi=lo=0, busy=0, no done pulse; hi_we with wdata=5 in the next IDLE cycle -> hi=5.
